// File: rtl/ir_cmd_ctrl.sv
// IR remote command controller: validates 32-bit IR frames, suppresses key repeats
// inside a hold-off window, and drives the player state and audio control levels.
module ir_cmd_ctrl #(
   parameter logic [22:0] HOLDOFF_CYC = 23'd5_000_000,
   parameter logic [7:0]  DEV_ADDR    = 8'h00
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        frame_valid,
   input  logic [31:0] frame_data,
   output logic        play,
   output logic        stop,
   output logic        pause,
   output logic        mute,
   output logic        seletor,
   output logic [3:0]  volume,
   output logic [3:0]  track,
   output logic        cmd_accept,
   output logic        cmd_reject
);

   localparam int unsigned HOLD_W = 23;

   localparam logic [7:0] KEY_PLAY  = 8'h30;
   localparam logic [7:0] KEY_STOP  = 8'h7A;
   localparam logic [7:0] KEY_PAUSE = 8'hC2;
   localparam logic [7:0] KEY_MUTE  = 8'h68;
   localparam logic [7:0] KEY_SEL   = 8'h18;
   localparam logic [7:0] KEY_VOLUP = 8'hA8;
   localparam logic [7:0] KEY_VOLDN = 8'hE0;
   localparam logic [7:0] KEY_NEXT  = 8'h02;
   localparam logic [7:0] KEY_PREV  = 8'h22;

   typedef enum logic [1:0] {
      ST_STOPPED = 2'd0,
      ST_PLAYING = 2'd1,
      ST_PAUSED  = 2'd2
   } state_t;

   state_t              state, nxt_state;
   logic [HOLD_W-1:0]   hold_cnt;
   logic [7:0]          last_cmd;
   logic                nxt_mute, nxt_seletor;
   logic [3:0]          nxt_volume, nxt_track;
   logic [7:0]          cmd_c;
   logic                frame_ok_c, known_c, repeat_c, accept_c;

   // Key code travels in the low byte; byte [15:8] carries its complement.
   assign cmd_c      = frame_data[7:0];
   assign frame_ok_c = (frame_data[31:24] == ~frame_data[23:16]) &&
                       (frame_data[23:16] == DEV_ADDR) &&
                       (frame_data[15:8]  == ~frame_data[7:0]);
   assign repeat_c   = (cmd_c == last_cmd) && (hold_cnt != '0);
   assign accept_c   = frame_valid && frame_ok_c && known_c && !repeat_c;

   always_comb begin
      known_c = 1'b0;
      case (cmd_c)
         KEY_PLAY, KEY_STOP, KEY_PAUSE, KEY_MUTE, KEY_SEL,
         KEY_VOLUP, KEY_VOLDN, KEY_NEXT, KEY_PREV: known_c = 1'b1;
         default:                                  known_c = 1'b0;
      endcase
   end

   // Next player/audio state for an accepted key
   always_comb begin
      nxt_state   = state;
      nxt_mute    = mute;
      nxt_seletor = seletor;
      nxt_volume  = volume;
      nxt_track   = track;
      if (accept_c) begin
         case (cmd_c)
            KEY_PLAY:  nxt_state = ST_PLAYING;
            KEY_STOP:  nxt_state = ST_STOPPED;
            KEY_PAUSE: begin
               if (state == ST_PLAYING)     nxt_state = ST_PAUSED;
               else if (state == ST_PAUSED) nxt_state = ST_PLAYING;
            end
            KEY_MUTE:  nxt_mute = ~mute;
            KEY_SEL:   if (state == ST_STOPPED) nxt_seletor = ~seletor;
            KEY_VOLUP: if (volume != 4'd15) nxt_volume = volume + 4'd1;
            KEY_VOLDN: if (volume != 4'd0)  nxt_volume = volume - 4'd1;
            KEY_NEXT:  nxt_track = (track == 4'd9) ? 4'd0 : track + 4'd1;
            KEY_PREV:  nxt_track = (track == 4'd0) ? 4'd9 : track - 4'd1;
            default:   nxt_state = state;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_STOPPED;
         play       <= 1'b0;
         stop       <= 1'b1;
         pause      <= 1'b0;
         mute       <= 1'b1;
         seletor    <= 1'b0;
         volume     <= 4'd8;
         track      <= 4'd0;
         hold_cnt   <= '0;
         last_cmd   <= 8'h00;
         cmd_accept <= 1'b0;
         cmd_reject <= 1'b0;
      end else begin
         state      <= nxt_state;
         play       <= (nxt_state == ST_PLAYING);
         stop       <= (nxt_state == ST_STOPPED);
         pause      <= (nxt_state == ST_PAUSED);
         mute       <= nxt_mute;
         seletor    <= nxt_seletor;
         volume     <= nxt_volume;
         track      <= nxt_track;
         cmd_accept <= accept_c;
         cmd_reject <= frame_valid && !accept_c;
         // Rejected repeats do not restart the window
         if (accept_c) begin
            hold_cnt <= HOLDOFF_CYC;
            last_cmd <= cmd_c;
         end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_ir_cmd_ctrl.sv
// Directed bench for ir_cmd_ctrl with a 16-cycle hold-off window.
module tb_ir_cmd_ctrl;

   localparam logic [31:0] F_PLAY  = 32'hFF00CF30;
   localparam logic [31:0] F_STOP  = 32'hFF00857A;
   localparam logic [31:0] F_PAUSE = 32'hFF003DC2;
   localparam logic [31:0] F_MUTE  = 32'hFF009768;
   localparam logic [31:0] F_SEL   = 32'hFF00E718;
   localparam logic [31:0] F_VOLUP = 32'hFF0057A8;
   localparam logic [31:0] F_VOLDN = 32'hFF001FE0;
   localparam logic [31:0] F_NEXT  = 32'hFF00FD02;
   localparam logic [31:0] F_PREV  = 32'hFF00DD22;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        frame_valid = 1'b0;
   logic [31:0] frame_data = '0;
   logic        play, stop, pause, mute, seletor, cmd_accept, cmd_reject;
   logic [3:0]  volume, track;

   int checks = 0;
   int errors = 0;

   ir_cmd_ctrl #(.HOLDOFF_CYC(23'd16), .DEV_ADDR(8'h00)) dut (
      .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid), .frame_data(frame_data),
      .play(play), .stop(stop), .pause(pause), .mute(mute), .seletor(seletor),
      .volume(volume), .track(track), .cmd_accept(cmd_accept), .cmd_reject(cmd_reject)
   );

   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge: present frame for one sampling edge, return at the next negedge
   task automatic send(input logic [31:0] d);
      frame_valid = 1'b1;
      frame_data  = d;
      @(negedge clk);
      frame_valid = 1'b0;
   endtask

   task automatic gap(input int k);
      repeat (k) @(negedge clk);
   endtask

   // state: 0 stopped, 1 playing, 2 paused
   task automatic check_all(input string tag, input int st, input logic m, input logic s,
                            input logic [3:0] v, input logic [3:0] t,
                            input logic acc, input logic rej);
      check({tag, ".play"},    32'(play),    32'(st == 1));
      check({tag, ".stop"},    32'(stop),    32'(st == 0));
      check({tag, ".pause"},   32'(pause),   32'(st == 2));
      check({tag, ".mute"},    32'(mute),    32'(m));
      check({tag, ".seletor"}, 32'(seletor), 32'(s));
      check({tag, ".volume"},  32'(volume),  32'(v));
      check({tag, ".track"},   32'(track),   32'(t));
      check({tag, ".accept"},  32'(cmd_accept), 32'(acc));
      check({tag, ".reject"},  32'(cmd_reject), 32'(rej));
   endtask

   initial begin
      gap(3);
      check_all("reset", 0, 1'b1, 1'b0, 4'd8, 4'd0, 1'b0, 1'b0);
      rst_n = 1'b1;
      gap(1);

      send(F_PLAY);  check_all("play",      1, 1'b1, 1'b0, 4'd8, 4'd0, 1'b1, 1'b0);
      gap(2);
      send(F_SEL);   check_all("sel_play",  1, 1'b1, 1'b0, 4'd8, 4'd0, 1'b1, 1'b0);
      send(F_STOP);  check_all("stop",      0, 1'b1, 1'b0, 4'd8, 4'd0, 1'b1, 1'b0);
      send(F_SEL);   check_all("sel_stop",  0, 1'b1, 1'b1, 4'd8, 4'd0, 1'b1, 1'b0);

      for (int i = 0; i < 10; i++) begin
         send(F_VOLUP);
         check($sformatf("volup%0d.volume", i), 32'(volume), (i < 7) ? 32'(9 + i) : 32'd15);
         check($sformatf("volup%0d.accept", i), 32'(cmd_accept), 32'd1);
         gap(19);
      end

      // Hold-off: repeats 5 and 16 cycles after an accept are dropped, 17 is not
      send(F_NEXT);  check_all("next1",     0, 1'b1, 1'b1, 4'd15, 4'd1, 1'b1, 1'b0);
      gap(4);
      send(F_NEXT);  check_all("next_rep5", 0, 1'b1, 1'b1, 4'd15, 4'd1, 1'b0, 1'b1);
      gap(11);
      send(F_NEXT);  check_all("next_17",   0, 1'b1, 1'b1, 4'd15, 4'd2, 1'b1, 1'b0);
      gap(15);
      send(F_NEXT);  check_all("next_h1",   0, 1'b1, 1'b1, 4'd15, 4'd2, 1'b0, 1'b1);
      send(F_NEXT);  check_all("next_h0",   0, 1'b1, 1'b1, 4'd15, 4'd3, 1'b1, 1'b0);

      send(32'hFF00CF31); check_all("bad_inv",  0, 1'b1, 1'b1, 4'd15, 4'd3, 1'b0, 1'b1);
      send(32'hFE01CF30); check_all("bad_addr", 0, 1'b1, 1'b1, 4'd15, 4'd3, 1'b0, 1'b1);
      send(32'hFF00FF00); check_all("unknown",  0, 1'b1, 1'b1, 4'd15, 4'd3, 1'b0, 1'b1);

      send(F_MUTE);  check_all("mute",      0, 1'b0, 1'b1, 4'd15, 4'd3, 1'b1, 1'b0);
      send(F_PAUSE); check_all("pause_stp", 0, 1'b0, 1'b1, 4'd15, 4'd3, 1'b1, 1'b0);
      send(F_PLAY);  check_all("play2",     1, 1'b0, 1'b1, 4'd15, 4'd3, 1'b1, 1'b0);
      send(F_PAUSE); check_all("pause",     2, 1'b0, 1'b1, 4'd15, 4'd3, 1'b1, 1'b0);
      send(F_VOLDN); check_all("voldn",     2, 1'b0, 1'b1, 4'd14, 4'd3, 1'b1, 1'b0);
      send(F_PLAY);  check_all("resume",    1, 1'b0, 1'b1, 4'd14, 4'd3, 1'b1, 1'b0);
      send(F_SEL);   check_all("sel_play2", 1, 1'b0, 1'b1, 4'd14, 4'd3, 1'b1, 1'b0);
      send(F_PREV);  check_all("prev",      1, 1'b0, 1'b1, 4'd14, 4'd2, 1'b1, 1'b0);

      // Async reset mid hold-off, overlapping a frame_valid
      gap(3);
      frame_valid = 1'b1;
      frame_data  = F_PREV;
      #2 rst_n = 1'b0;
      #1 check_all("rst_async", 0, 1'b1, 1'b0, 4'd8, 4'd0, 1'b0, 1'b0);
      @(negedge clk);
      check_all("rst_hold", 0, 1'b1, 1'b0, 4'd8, 4'd0, 1'b0, 1'b0);
      frame_valid = 1'b0;
      rst_n = 1'b1;
      send(F_PREV);  check_all("prev_wrap", 0, 1'b1, 1'b0, 4'd8, 4'd9, 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
